// File: rtl/mpu_frame_asm.sv
// +-----------------------------------------------------------------------------+
// | Module : mpu_frame_asm                                                      |
// | Brief  : Assembles the MPU sensor byte stream into 16-bit big-endian words  |
// |          and commits each complete frame atomically into a readable bank.   |
// |          Optional idle timeout: define MPU_FRAME_TIMEOUT_EN.                |
// | Rev    : 1.0  initial release                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module mpu_frame_asm #(
    parameter int NWORDS  = 7,
    parameter int TIMEOUT = 4096
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  DATA_IN,
    input  logic        DATA_EN,
    input  logic        DATA_ST,
    input  logic [2:0]  RD_ADDR,
    output logic [15:0] RD_DATA,
    output logic        FRAME_VALID,
    output logic [15:0] FRAME_CNT,
    output logic        ERR_SHORT,
    output logic        ERR_LONG,
    input  logic        ERR_CLR
);

    localparam logic [3:0] c_NWORDS   = 4'(NWORDS);
    localparam logic [3:0] c_LAST_IDX = 4'(2 * NWORDS - 1);

    if (NWORDS < 1 || NWORDS > 7 || TIMEOUT < 2 || TIMEOUT > 8192) begin : g_bad_param
        $error("mpu_frame_asm: NWORDS must be 1..7 and TIMEOUT 2..8192");
    end

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_COLLECT = 1'b1
    } t_state;

    t_state      r_state;
    logic [3:0]  r_idx;
    logic [7:0]  r_hi;
    logic [15:0] r_shadow [0:NWORDS-1];
    logic [15:0] r_vis    [0:NWORDS-1];
    logic [15:0] w_word;
    logic [15:0] w_rd_data;

`ifdef MPU_FRAME_TIMEOUT_EN
    localparam logic [12:0] c_TO_LAST = 13'(TIMEOUT - 1);
    logic [12:0] r_idle;
`endif

    assign w_word = {r_hi, DATA_IN};

    // Addresses past the frame but below 7 read as zero.
    always_comb begin
        w_rd_data = '0;
        if ({1'b0, RD_ADDR} < c_NWORDS) begin
            w_rd_data = r_vis[RD_ADDR];
        end else if (RD_ADDR == 3'd7) begin
            w_rd_data = FRAME_CNT;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_hi        <= '0;
            RD_DATA     <= '0;
            FRAME_VALID <= 1'b0;
            FRAME_CNT   <= '0;
            ERR_SHORT   <= 1'b0;
            ERR_LONG    <= 1'b0;
            for (int i = 0; i < NWORDS; i++) begin
                r_shadow[i] <= '0;
                r_vis[i]    <= '0;
            end
`ifdef MPU_FRAME_TIMEOUT_EN
            r_idle      <= '0;
`endif
        end else begin
            FRAME_VALID <= 1'b0;
            RD_DATA     <= w_rd_data;
            if (ERR_CLR) begin
                ERR_SHORT <= 1'b0;
                ERR_LONG  <= 1'b0;
            end
`ifdef MPU_FRAME_TIMEOUT_EN
            r_idle <= '0;
`endif
            if (DATA_ST) begin
                // A start strobe always wins; a coincident byte becomes byte 0.
                if (r_state == S_COLLECT) begin
                    ERR_SHORT <= 1'b1;
                end
                r_state <= S_COLLECT;
                if (DATA_EN) begin
                    r_hi  <= DATA_IN;
                    r_idx <= 4'd1;
                end else begin
                    r_idx <= '0;
                end
            end else if (DATA_EN) begin
                if (r_state == S_IDLE) begin
                    ERR_LONG <= 1'b1;
                end else begin
                    if (!r_idx[0]) begin
                        r_hi <= DATA_IN;
                    end else begin
                        r_shadow[r_idx[3:1]] <= w_word;
                    end
                    if (r_idx == c_LAST_IDX) begin
                        for (int i = 0; i < NWORDS; i++) begin
                            r_vis[i] <= (3'(i) == r_idx[3:1]) ? w_word : r_shadow[i];
                        end
                        FRAME_CNT   <= FRAME_CNT + 16'd1;
                        FRAME_VALID <= 1'b1;
                        r_state     <= S_IDLE;
                        r_idx       <= '0;
                    end else begin
                        r_idx <= r_idx + 4'd1;
                    end
                end
            end else if (r_state == S_COLLECT) begin
`ifdef MPU_FRAME_TIMEOUT_EN
                if (r_idle == c_TO_LAST) begin
                    ERR_SHORT <= 1'b1;
                    r_state   <= S_IDLE;
                    r_idx     <= '0;
                end else begin
                    r_idle <= r_idle + 13'd1;
                end
`endif
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/mpu_frame_asm.md
# mpu_frame_asm

Downstream consumer of the I2C master's sensor read stream. Collects the byte stream (DATA_OUT/DATA_EN) that follows each update-start strobe (DATA_ST) into a frame of big-endian 16-bit words (accel X/Y/Z, temp, gyro X/Y/Z). Commits each complete frame atomically into a CPU-visible register bank. Flags short and overlong frames, and counts completed frames.

## Interface
Parameters:
- NWORDS, default 7: 16-bit words per frame. Frame length is 2*NWORDS bytes. Legal range 1..7.
- TIMEOUT, default 4096: maximum idle cycles between bytes inside a frame. Used only with MPU_FRAME_TIMEOUT_EN.

Ports:
- CLK, in, 1: clock.
- RESET, in, 1: synchronous, active-high reset.
- DATA_IN, in, 8: received byte, sampled when DATA_EN=1.
- DATA_EN, in, 1: single-cycle byte-valid strobe.
- DATA_ST, in, 1: single-cycle frame-start strobe.
- RD_ADDR, in, 3: CPU word select. 0..NWORDS-1 select frame words, 7 selects FRAME_CNT, any other value reads 0.
- RD_DATA, out, 16: registered read data.
- FRAME_VALID, out, 1: one-cycle pulse when a frame is committed.
- FRAME_CNT, out, 16: count of committed frames, wraps modulo 2^16.
- ERR_SHORT, out, 1: sticky. A frame was abandoned before it completed.
- ERR_LONG, out, 1: sticky. A byte arrived outside any frame.
- ERR_CLR, in, 1: clears both sticky error flags.

## Operation
- State machine with two states, IDLE and COLLECT. RESET sets the state to IDLE.
- Internal storage:
  - byte index `idx`, 4 bits;
  - high-byte latch `hi`, 8 bits;
  - shadow bank of NWORDS x 16;
  - visible bank of NWORDS x 16.
- IDLE:
  - DATA_ST: go to COLLECT, idx=0.
  - DATA_EN without DATA_ST: drop the byte and set ERR_LONG.
- COLLECT, DATA_EN:
  - Even idx: hi <= DATA_IN.
  - Odd idx: shadow[idx>>1] <= {hi, DATA_IN}.
  - In both cases idx <= idx+1.
- End of frame: the byte with idx = 2*NWORDS-1 completes the frame. On that edge:
  - the whole shadow bank, including the word being written, is copied into the visible bank;
  - FRAME_CNT increments;
  - FRAME_VALID is 1 for the next cycle;
  - state returns to IDLE.
- DATA_ST while in COLLECT: the partial frame is discarded, ERR_SHORT is set, idx restarts at 0, and the state stays COLLECT. The visible bank is untouched.
- DATA_ST and DATA_EN in the same cycle, either state: the start strobe wins. The byte is taken as byte 0 of the new frame and idx becomes 1. ERR_LONG is not set by this case.
- The visible bank changes only on a commit. A partial frame never alters it.
- ERR_CLR and an error-setting event in the same cycle: the set wins.
- Widths: FRAME_CNT wraps from 0xFFFF to 0x0000. Words are stored as raw bits; no sign handling.

## Timing
- Reset values: RD_DATA=0, FRAME_VALID=0, FRAME_CNT=0, ERR_SHORT=0, ERR_LONG=0. Both banks are all-zero.
- Read latency is 1 cycle: RD_DATA is registered from RD_ADDR at the clock edge.
- Read in the same cycle as a commit edge returns the pre-commit value. The new value is visible one cycle later.
- FRAME_VALID rises in the cycle after the final byte's DATA_EN and lasts exactly 1 cycle.
- The FRAME_CNT update and the visible-bank update both occur on the same edge as the final-byte capture.
- Error flags update on the edge following the causing strobe.
- RESET asserted mid-frame: state returns to IDLE and all outputs and banks return to their reset values. No error flag is set.
- Back-to-back DATA_EN on consecutive cycles is supported. No throughput limit applies.

## Configuration
- MPU_FRAME_TIMEOUT_EN defined: a 13-bit idle counter runs while in COLLECT.
  - The counter clears on every DATA_EN and every DATA_ST.
  - When it reaches TIMEOUT-1, the partial frame is dropped, ERR_SHORT is set, and the state goes to IDLE.
- MPU_FRAME_TIMEOUT_EN not defined: the counter is not built, and COLLECT waits indefinitely for bytes.

## Test plan
- Nominal frame: DATA_ST, then 14 bytes 0x01..0x0E. Expect FRAME_VALID once. Reading words 0..6 returns 0x0102, 0x0304, ..., 0x0D0E. RD_ADDR=7 returns FRAME_CNT=1. No errors.
- Short frame: DATA_ST, 5 bytes, DATA_ST, then 14 bytes of 0xAA. Expect ERR_SHORT=1, one commit, all words 0xAAAA.
- Stray byte: DATA_EN=1 with 0x55 in IDLE. Expect ERR_LONG=1 and the visible bank unchanged. Then ERR_CLR=1, and both flags read 0.
- Simultaneous strobes: DATA_ST and DATA_EN with 0x12 in the same cycle, followed by 13 bytes of 0x34. Expect word0=0x1234 and ERR_LONG=0.
- Read/commit race and wrap: preload FRAME_CNT to 0xFFFF through 65535 frames (or a forced value). Read word0 on the commit edge and expect the old value; one cycle later expect the new value. Expect FRAME_CNT=0x0000.
- With MPU_FRAME_TIMEOUT_EN and TIMEOUT=16: DATA_ST, 3 bytes, then 20 idle cycles. Expect ERR_SHORT=1 and state IDLE. A later 14-byte frame commits normally.
